// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: a small FIFO of fetched {instr, pc} pairs between
// the fetch and decode stages. The head entry is presented to ID from
// registered storage, and an EX redirect discards everything in flight.
// Optional build macro: IFID_PERF_CNT_EN adds saturating stall/flush counters.
module if_id_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_if_valid,
    input  logic [31:0]                  i_if_instr,
    input  logic [63:0]                  i_if_pc,
    output logic                         o_if_ready,
    input  logic                         i_ex_flush,
    output logic                         o_id_valid,
    output logic [31:0]                  o_id_instr,
    output logic [63:0]                  o_id_pc,
    input  logic                         i_id_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]                  o_stall_cnt,
    output logic [15:0]                  o_flush_cnt
`endif
);

    localparam int          PTR_W = $clog2(DEPTH);
    localparam int          CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } entry_t;

    // Pointer arithmetic relies on natural wrap, so DEPTH must be a power of two.
    if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
        $error("if_id_buffer: DEPTH must be 2, 4 or 8");
    end

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               if_ready;
    logic               id_valid;
    logic               push;
    logic               pop;

    // Handshake flags derive from registered occupancy only, so i_id_ready
    // never reaches o_if_ready combinationally; a full buffer that is popped
    // reopens on the following cycle.
    assign if_ready = (count_q < CNT_W'(DEPTH));
    assign id_valid = (count_q != '0);

    // Next-state for pointers and occupancy; flush overrides any push/pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push     = i_if_valid & if_ready & ~i_ex_flush;
        pop      = id_valid & i_id_ready & ~i_ex_flush;
        if (i_ex_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage written at the tail on each accepted push.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; entries are masked by id_valid until written.
        if (push) mem_q[wr_ptr_q] <= '{instr: i_if_instr, pc: i_if_pc};
    end

    assign o_if_ready  = if_ready;
    assign o_id_valid  = id_valid;
    assign o_id_instr  = id_valid ? mem_q[rd_ptr_q].instr : NOP;
    assign o_id_pc     = id_valid ? mem_q[rd_ptr_q].pc    : 64'h0;
    assign o_occupancy = count_q;

`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: fetch stalls on a full buffer, flushes that discard work.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (i_if_valid && !if_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        if (i_ex_flush && id_valid && flush_cnt_q != '1)  flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer (DEPTH = 2): a directed vector table,
// continuous streaming, randomized traffic against a queue model, and
// asynchronous reset mid-operation.
module tb_if_id_buffer;

    localparam int          DEPTH = 2;
    localparam int          OCC_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_if_valid = 1'b0;
    logic [31:0]      i_if_instr = '0;
    logic [63:0]      i_if_pc = '0;
    logic             o_if_ready;
    logic             i_ex_flush = 1'b0;
    logic             o_id_valid;
    logic [31:0]      o_id_instr;
    logic [63:0]      o_id_pc;
    logic             i_id_ready = 1'b0;
    logic [OCC_W-1:0] o_occupancy;
`ifdef IFID_PERF_CNT_EN
    logic [31:0]      o_stall_cnt;
    logic [15:0]      o_flush_cnt;
`endif

    if_id_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_if_valid  (i_if_valid),
        .i_if_instr  (i_if_instr),
        .i_if_pc     (i_if_pc),
        .o_if_ready  (o_if_ready),
        .i_ex_flush  (i_ex_flush),
        .o_id_valid  (o_id_valid),
        .o_id_instr  (o_id_instr),
        .o_id_pc     (o_id_pc),
        .i_id_ready  (i_id_ready),
        .o_occupancy (o_occupancy)
`ifdef IFID_PERF_CNT_EN
        ,
        .o_stall_cnt (o_stall_cnt),
        .o_flush_cnt (o_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a plain queue of fetched pairs plus perf tallies.
    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } pair_t;
    pair_t       model_q[$];
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    // Directed vector: inputs for one cycle and the expected state after the edge.
    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic        flush;
        logic        rdy;
        logic        e_valid;
        logic [63:0] e_pc;
        int          e_occ;
        logic        e_ready;
    } vec_t;
    vec_t vecs [15];

    function automatic logic [31:0] mk_instr(input logic [63:0] pc);
        return 32'h0050_0093 ^ {pc[9:0], 22'h0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model by the same rules, sample #1 after the edge.
    task automatic step(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                        input logic flush, input logic rdy);
        bit m_ready, m_valid;
        i_if_valid = v;
        i_if_instr = instr;
        i_if_pc    = pc;
        i_ex_flush = flush;
        i_id_ready = rdy;
        m_ready = (model_q.size() < DEPTH);
        m_valid = (model_q.size() != 0);
        @(posedge clk);
        if (v && !m_ready) m_stall++;
        if (flush && m_valid) m_flush++;
        if (flush) begin
            model_q.delete();
        end else begin
            if (m_valid && rdy) void'(model_q.pop_front());
            if (v && m_ready)   model_q.push_back('{instr: instr, pc: pc});
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        bit          e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        e_valid = (model_q.size() != 0);
        e_pc    = e_valid ? model_q[0].pc : 64'h0;
        e_instr = e_valid ? model_q[0].instr : NOP;
        check({tag, " occ"},   64'(o_occupancy), 64'(model_q.size()));
        check({tag, " valid"}, 64'(o_id_valid), 64'(e_valid));
        check({tag, " ready"}, 64'(o_if_ready), 64'(model_q.size() < DEPTH));
        check({tag, " pc"},    o_id_pc, e_pc);
        check({tag, " instr"}, 64'(o_id_instr), 64'(e_instr));
`ifdef IFID_PERF_CNT_EN
        check({tag, " stall_cnt"}, 64'(o_stall_cnt), 64'(m_stall));
        check({tag, " flush_cnt"}, 64'(o_flush_cnt), 64'(m_flush));
`endif
    endtask

    initial begin
        logic [63:0] prev_pc;
        logic [63:0] rpc;

        //            v  pc        fl rdy  e_valid e_pc      occ ready
        vecs = '{
            '{1'b1, 64'h00, 1'b0, 1'b1, 1'b1, 64'h00, 1, 1'b1},  // push 0x0 into empty
            '{1'b0, 64'h00, 1'b0, 1'b1, 1'b0, 64'h00, 0, 1'b1},  // popped next cycle
            '{1'b1, 64'h00, 1'b0, 1'b0, 1'b1, 64'h00, 1, 1'b1},  // fill with ID stalled
            '{1'b1, 64'h04, 1'b0, 1'b0, 1'b1, 64'h00, 2, 1'b0},  // now full
            '{1'b1, 64'h08, 1'b0, 1'b0, 1'b1, 64'h00, 2, 1'b0},  // third not accepted
            '{1'b1, 64'h08, 1'b0, 1'b1, 1'b1, 64'h04, 1, 1'b1},  // full + pop: pop only
            '{1'b1, 64'h08, 1'b0, 1'b1, 1'b1, 64'h08, 1, 1'b1},  // push+pop, 0x8 at head
            '{1'b0, 64'h00, 1'b0, 1'b1, 1'b0, 64'h00, 0, 1'b1},  // drain
            '{1'b1, 64'h10, 1'b0, 1'b0, 1'b1, 64'h10, 1, 1'b1},
            '{1'b1, 64'h14, 1'b0, 1'b0, 1'b1, 64'h10, 2, 1'b0},
            '{1'b1, 64'h18, 1'b1, 1'b1, 1'b0, 64'h00, 0, 1'b1},  // flush a full buffer
            '{1'b1, 64'h20, 1'b0, 1'b0, 1'b1, 64'h20, 1, 1'b1},  // push accepted after flush
            '{1'b0, 64'h00, 1'b1, 1'b1, 1'b0, 64'h00, 0, 1'b1},  // flush suppresses pop
            '{1'b1, 64'h28, 1'b1, 1'b1, 1'b0, 64'h00, 0, 1'b1},  // flush on empty, push dropped
            '{1'b1, 64'h30, 1'b0, 1'b1, 1'b1, 64'h30, 1, 1'b1}
        };

        // Asynchronous reset state, checked before any clock edge.
        #2;
        check("reset occ",   64'(o_occupancy), 64'h0);
        check("reset valid", 64'(o_id_valid), 64'h0);
        check("reset ready", 64'(o_if_ready), 64'h1);
        check("reset instr", 64'(o_id_instr), 64'(NOP));
        check("reset pc",    o_id_pc, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].v, mk_instr(vecs[i].pc), vecs[i].pc, vecs[i].flush, vecs[i].rdy);
            check($sformatf("vec%0d occ", i),   64'(o_occupancy), 64'(vecs[i].e_occ));
            check($sformatf("vec%0d valid", i), 64'(o_id_valid), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d ready", i), 64'(o_if_ready), 64'(vecs[i].e_ready));
            check($sformatf("vec%0d pc", i),    o_id_pc, vecs[i].e_pc);
            check($sformatf("vec%0d instr", i), 64'(o_id_instr),
                  64'(vecs[i].e_valid ? mk_instr(vecs[i].e_pc) : NOP));
        end

        // Continuous streaming: one in, one out per cycle across many pointer wraps.
        prev_pc = o_id_pc;
        for (int i = 0; i < 20; i++) begin
            rpc = 64'h34 + 64'(4 * i);
            step(1'b1, mk_instr(rpc), rpc, 1'b0, 1'b1);
            check($sformatf("stream%0d pc+4", i), o_id_pc, prev_pc + 64'h4);
            check($sformatf("stream%0d occ", i), 64'(o_occupancy), 64'h1);
            prev_pc = o_id_pc;
        end

        // Fill, then show o_if_ready does not react combinationally to i_id_ready.
        step(1'b1, mk_instr(64'h200), 64'h200, 1'b0, 1'b0);
        step(1'b1, mk_instr(64'h204), 64'h204, 1'b0, 1'b0);
        check_model("fill");
        i_id_ready = 1'b1;
        #1;
        check("ready no comb path", 64'(o_if_ready), 64'h0);
        step(1'b1, mk_instr(64'h208), 64'h208, 1'b0, 1'b1);
        check_model("pop only");

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, {$urandom, $urandom},
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
            check_model($sformatf("rand%0d", i));
        end

        // Fill, then reset asynchronously between edges.
        step(1'b1, mk_instr(64'h300), 64'h300, 1'b0, 1'b0);
        step(1'b1, mk_instr(64'h304), 64'h304, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst occ",   64'(o_occupancy), 64'h0);
        check("midrst valid", 64'(o_id_valid), 64'h0);
        check("midrst ready", 64'(o_if_ready), 64'h1);
        check("midrst instr", 64'(o_id_instr), 64'(NOP));
        check("midrst pc",    o_id_pc, 64'h0);
        model_q.delete();
        m_stall = 0;
        m_flush = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, mk_instr(64'h400), 64'h400, 1'b0, 1'b0);
        check("post-reset push occ", 64'(o_occupancy), 64'h1);
        check("post-reset push pc",  o_id_pc, 64'h400);

`ifdef IFID_PERF_CNT_EN
        // Five full-buffer stall cycles, then one flush of an occupied buffer.
        step(1'b1, mk_instr(64'h404), 64'h404, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, mk_instr(64'h408), 64'h408, 1'b0, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        check("perf stall_cnt", 64'(o_stall_cnt), 64'd5);
        check("perf flush_cnt", 64'(o_flush_cnt), 64'd1);
        check_model("perf end");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter DEPTH, default 2, number of buffered fetch entries; legal values 2, 4, 8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_if_valid  input  1  IF presents a valid instruction/PC pair.
REQ-005 i_if_instr  input  32  fetched instruction.
REQ-006 i_if_pc  input  64  PC of fetched instruction.
REQ-007 o_if_ready  output  1  buffer accepts a push this cycle; drives IF i_id_ready.
REQ-008 i_ex_flush  input  1  EX redirect (taken branch/jump); discard all buffered entries.
REQ-009 o_id_valid  output  1  head entry valid toward ID.
REQ-010 o_id_instr  output  32  head instruction, or NOP when invalid.
REQ-011 o_id_pc  output  64  head PC.
REQ-012 i_id_ready  input  1  ID consumes head this cycle.
REQ-013 o_occupancy  output  $clog2(DEPTH+1)  current entry count.

Function
REQ-014 Push = i_if_valid & o_if_ready & ~i_ex_flush; pop = o_id_valid & i_id_ready & ~i_ex_flush.
REQ-015 o_if_ready = (occupancy < DEPTH), from registered state only; no combinational path from i_id_ready to o_if_ready.
REQ-016 Full buffer with simultaneous pop: no push that cycle; o_if_ready rises next cycle.
REQ-017 Pushed entry is visible at the outputs no earlier than the following cycle (1-cycle latency when empty).
REQ-018 o_id_valid = (occupancy != 0); o_id_instr/o_id_pc come from the head entry of registered storage.
REQ-019 When o_id_valid = 0, o_id_instr = 32'h0000_0013 (addi x0,x0,0) and o_id_pc = 0.
REQ-020 Order strictly FIFO; read/write pointers wrap modulo DEPTH.
REQ-021 Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, both pointers advance.
REQ-022 Push and pop in the same cycle with occupancy 0 is impossible (o_id_valid = 0); the entry is pushed only.
REQ-023 i_ex_flush = 1: next cycle occupancy = 0, pointers = 0; the same-cycle push and pop are both suppressed.
REQ-024 i_ex_flush has priority over all other events; flush on an empty buffer has no other effect.
REQ-025 Data held stable while o_id_valid = 1 and i_id_ready = 0.

Reset
REQ-026 rst_n low asynchronously forces occupancy 0, pointers 0, o_id_valid 0, o_id_instr NOP, o_id_pc 0, o_if_ready 1.
REQ-027 Reset asserted mid-operation discards all entries; the first push is accepted on the first rising edge after rst_n deasserts.
REQ-028 Storage array contents need not be reset; they are unobservable while invalid.

Configuration
REQ-029 Macro IFID_PERF_CNT_EN defined: add outputs o_stall_cnt (32b, increments every cycle with i_if_valid & ~o_if_ready) and o_flush_cnt (16b, increments per cycle with i_ex_flush & occupancy != 0); both saturate and reset to 0.
REQ-030 IFID_PERF_CNT_EN undefined: counter ports and logic are absent; all other behaviour identical.

Verification
REQ-031 Reset, then push instr 0x00500093 @ pc 0x0 with i_id_ready=1 -> o_id_valid=1 next cycle with matching instr/pc; popped the cycle after.
REQ-032 i_id_ready=0, push 3 entries (DEPTH=2) -> occupancy 2, o_if_ready=0, third entry not accepted, head = first pc 0x0.
REQ-033 Full, i_id_ready=1 and i_if_valid=1 -> pop only; occupancy 1, o_if_ready=1 next cycle; stream pcs 0x0,0x4,0x8 emerge in order.
REQ-034 Occupancy 2, assert i_ex_flush with i_if_valid=1 -> next cycle occupancy 0, o_id_instr=0x00000013, new push accepted the following cycle.
REQ-035 Continuous push/pop for 20 cycles -> pointer wrap, no loss/duplication, o_id_pc increments by 4 each cycle.
REQ-036 With IFID_PERF_CNT_EN defined: 5 full-stall cycles and 1 flush of an occupied buffer -> o_stall_cnt=5, o_flush_cnt=1.
